// File: rtl/pll_reset_ce_gen.sv
// pll_reset_ce_gen: reset sequencer and clock-enable generator in the PLL output domain.
//   Waits for the synchronised PLL lock to stay stable for LOCK_STABLE_CYCLES cycles.
//   It then holds the core in reset for RESET_HOLD_CYCLES cycles with the clock
//   enables already running, and then releases the reset.
//   Losing lock while running returns the block to the lock wait and sets a sticky flag.
// Ports:
//   clk           PLL output clock
//   rst           asynchronous active-high reset
//   locked        PLL lock flag (asynchronous to clk)
//   ext_reset     synchronous level reset request, honoured only while running
//   lock_lost_clr synchronous clear of lock_lost
//   reset_out     registered active-high core reset
//   ce_pix        one-cycle pulse every DIV cycles
//   ce_2x         one-cycle pulse every DIV/2 cycles
//   lock_lost     sticky flag: lock dropped while running
module pll_reset_ce_gen #(
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned RESET_HOLD_CYCLES  = 256,
  parameter int unsigned DIV                = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic locked,
  input  logic ext_reset,
  input  logic lock_lost_clr,
  output logic reset_out,
  output logic ce_pix,
  output logic ce_2x,
  output logic lock_lost
);

  localparam int unsigned SW = $clog2(LOCK_STABLE_CYCLES) + 1;
  localparam int unsigned HW = $clog2(RESET_HOLD_CYCLES) + 1;
  localparam int unsigned DW = $clog2(DIV);

  localparam logic [SW-1:0] StableLast = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [HW-1:0] HoldLast   = HW'(RESET_HOLD_CYCLES - 1);
  localparam logic [DW-1:0] DivLast    = DW'(DIV - 1);
  localparam logic [DW-1:0] DivHalf    = DW'(DIV / 2 - 1);

  typedef enum logic [1:0] {StWait, StStable, StHold, StRun} state_e;

  state_e          state_q, state_d;
  logic            sync_meta_q, locked_s;
  logic [SW-1:0]   stable_cnt_q, stable_cnt_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [DW-1:0]   div_cnt_q, div_cnt_d;
  logic            reset_out_q, ce_pix_q, ce_2x_q, lock_lost_q;
  logic            reset_out_d, ce_pix_d, ce_2x_d, lock_lost_d;
  logic            lost_set;
  logic            run_q, run_d;

  // Next-state logic.
  always_comb begin
    state_d      = state_q;
    stable_cnt_d = stable_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    lost_set     = 1'b0;
    case (state_q)
      StWait: begin
        if (locked_s) begin
          state_d      = StStable;
          stable_cnt_d = '0;
        end
      end
      StStable: begin
        if (!locked_s) begin
          state_d = StWait;
        end else if (stable_cnt_q == StableLast) begin
          state_d    = StHold;
          hold_cnt_d = '0;
        end else begin
          stable_cnt_d = stable_cnt_q + SW'(1);
        end
      end
      StHold: begin
        if (!locked_s) begin
          state_d = StWait;
        end else if (hold_cnt_q == HoldLast) begin
          state_d = StRun;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      StRun: begin
        // Lock loss outranks a user reset request.
        if (!locked_s) begin
          state_d  = StWait;
          lost_set = 1'b1;
        end else if (ext_reset) begin
          state_d    = StHold;
          hold_cnt_d = '0;
        end
      end
      default: state_d = StWait;
    endcase
  end

  // Divider and output next values.
  always_comb begin
    run_q = (state_q == StHold) || (state_q == StRun);
    run_d = (state_d == StHold) || (state_d == StRun);
    // Divider restarts from 0 on every entry into HOLD from STABLE; a RUN->HOLD
    // re-entry keeps counting so the enable cadence has no phase jump.
    div_cnt_d = '0;
    if (run_q && run_d) begin
      div_cnt_d = (div_cnt_q == DivLast) ? '0 : div_cnt_q + DW'(1);
    end
    // Gated by run_d so a lock drop kills the enables on the very same edge.
    ce_pix_d    = run_d && (div_cnt_q == DivLast);
    ce_2x_d     = run_d && ((div_cnt_q == DivLast) || (div_cnt_q == DivHalf));
    reset_out_d = (state_d != StRun);
    lock_lost_d = lost_set ? 1'b1 : (lock_lost_clr ? 1'b0 : lock_lost_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta_q  <= 1'b0;
      locked_s     <= 1'b0;
      state_q      <= StWait;
      stable_cnt_q <= '0;
      hold_cnt_q   <= '0;
      div_cnt_q    <= '0;
      reset_out_q  <= 1'b1;
      ce_pix_q     <= 1'b0;
      ce_2x_q      <= 1'b0;
      lock_lost_q  <= 1'b0;
    end else begin
      sync_meta_q  <= locked;
      locked_s     <= sync_meta_q;
      state_q      <= state_d;
      stable_cnt_q <= stable_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      div_cnt_q    <= div_cnt_d;
      reset_out_q  <= reset_out_d;
      ce_pix_q     <= ce_pix_d;
      ce_2x_q      <= ce_2x_d;
      lock_lost_q  <= lock_lost_d;
    end
  end

  assign reset_out = reset_out_q;
  assign ce_pix    = ce_pix_q;
  assign ce_2x     = ce_2x_q;
  assign lock_lost = lock_lost_q;

endmodule

// File: tb/tb_pll_reset_ce_gen.sv
// Testbench for pll_reset_ce_gen: a timestamp-based reference model pushes the expected
// {reset_out, ce_pix, ce_2x, lock_lost} for every clock edge; a monitor pops and compares.
module tb_pll_reset_ce_gen;

  localparam int L = 16;
  localparam int H = 32;
  localparam int D = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic locked = 1'b0;
  logic ext_reset = 1'b0;
  logic lock_lost_clr = 1'b0;
  logic reset_out, ce_pix, ce_2x, lock_lost;

  logic [3:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pll_reset_ce_gen #(
    .LOCK_STABLE_CYCLES(L),
    .RESET_HOLD_CYCLES (H),
    .DIV               (D)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .locked       (locked),
    .ext_reset    (ext_reset),
    .lock_lost_clr(lock_lost_clr),
    .reset_out    (reset_out),
    .ce_pix       (ce_pix),
    .ce_2x        (ce_2x),
    .lock_lost    (lock_lost)
  );

  // Reference model. Edge n counts posedges since reset release. The lock flag seen by
  // the sequencer at edge n is the value sampled at edge n-2. lock_since is the first
  // edge of the current unbroken run of synchronised lock. Reset hold starts L edges
  // later, or at a user reset while running. Reset releases H edges after hold start.
  // Enables are phase-locked to lock_since+L.
  initial begin : model
    bit hist[$];
    int n, lock_since, hold_start, k;
    bit ls, was_run, m_run, m_lost, e_pix, e_2x;
    n = 0; lock_since = -1; hold_start = -1; m_run = 0; m_lost = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        hist.delete();
        n = 0; lock_since = -1; hold_start = -1; m_run = 0; m_lost = 0;
        exp_q.push_back(4'b1000);
      end else begin
        ls      = (hist.size() >= 2) ? hist[hist.size() - 2] : 1'b0;
        was_run = m_run;
        if (!ls && was_run) m_lost = 1'b1;
        else if (lock_lost_clr) m_lost = 1'b0;
        if (!ls) begin
          lock_since = -1;
          hold_start = -1;
        end else begin
          if (lock_since < 0) lock_since = n;
          if (hold_start < 0 && n >= lock_since + L) hold_start = lock_since + L;
          if (was_run && ext_reset) hold_start = n;
        end
        m_run = (hold_start >= 0) && (n >= hold_start + H);
        k     = n - (lock_since + L);
        e_pix = (hold_start >= 0) && (k > 0) && (k % D == 0);
        e_2x  = (hold_start >= 0) && (k > 0) && (k % (D / 2) == 0);
        exp_q.push_back({!m_run, e_pix, e_2x, m_lost});
        hist.push_back(locked);
        n++;
      end
    end
  end

  // Monitor: compares on the falling edge, away from the active edge.
  initial begin : monitor
    logic [3:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({reset_out, ce_pix, ce_2x, lock_lost} !== e) begin
          errors++;
          $display("FAIL outputs t=%0t got reset/pix/2x/lost=%b want %b", $time,
                   {reset_out, ce_pix, ce_2x, lock_lost}, e);
        end
      end
    end
  end

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Off-edge asynchronous reset with an immediate check of the reset values.
  task automatic async_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    checks++;
    if ({reset_out, ce_pix, ce_2x, lock_lost} !== 4'b1000) begin
      errors++;
      $display("FAIL async_reset got reset/pix/2x/lost=%b want 1000",
               {reset_out, ce_pix, ce_2x, lock_lost});
    end
    step(2);
    rst = 1'b0;
  endtask

  task automatic pulse_ext(input int len);
    ext_reset = 1'b1;
    step(len);
    ext_reset = 1'b0;
  endtask

  task automatic pulse_clr();
    lock_lost_clr = 1'b1;
    step(1);
    lock_lost_clr = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin : stim
    int r;
    // Power-up with constant lock.
    locked = 1'b1;
    step(3);
    rst = 1'b0;
    step(90);

    // Lock glitch during the stability count.
    async_reset();
    step(10);
    locked = 1'b0;
    step(3);
    locked = 1'b1;
    step(90);

    // Lock loss while running, then relock.
    locked = 1'b0;
    step(5);
    locked = 1'b1;
    step(70);

    // Single-cycle and multi-cycle user resets while running.
    pulse_ext(1);
    step(45);
    step($urandom_range(1, 7));
    pulse_ext(3);
    step(45);

    // Clear colliding with a lock-loss set, then a clear alone.
    pulse_clr();
    step(2);
    locked = 1'b0;
    step(2);
    pulse_clr();
    step(3);
    locked = 1'b1;
    step(70);
    pulse_clr();
    step(5);

    // Async reset mid-run, then the power-up sequence again.
    step($urandom_range(0, 7));
    async_reset();
    step(90);

    // Randomised mix.
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 11);
      if (r == 0) begin
        locked = 1'b0;
        step($urandom_range(1, 4));
        locked = 1'b1;
      end else if (r <= 3) begin
        pulse_ext($urandom_range(1, 3));
      end else if (r == 4) begin
        pulse_clr();
      end else if (r == 5 && i % 50 == 7) begin
        async_reset();
      end else begin
        step($urandom_range(1, 20));
      end
    end
    step(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
